// File: rtl/pulse_monitor_pkg.sv
// ============================================================================
// Module   : pulse_monitor_pkg
// Purpose  : Shared state encoding and default parameters for pulse_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    localparam int DEF_N        = 7500;
    localparam int DEF_CBITS    = 13;
    localparam int DEF_TOL      = 2;
    localparam int DEF_LOCK_CNT = 2;

endpackage

`default_nettype wire

// File: rtl/gap_counter.sv
// ============================================================================
// Module   : gap_counter
// Purpose  : Cycles-since-last-pulse counter with restart and saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gap_counter #(
    parameter int CBITS = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             restart_i,
    output logic [CBITS-1:0] gap_o
);

    localparam logic [CBITS-1:0] C_GAP_MAX = {CBITS{1'b1}};

    logic [CBITS-1:0] gap_q;
    logic [CBITS-1:0] gap_d;

    always_comb begin
        gap_d = gap_q;
        if (clear_i) begin
            gap_d = '0;
        end else if (restart_i) begin
            gap_d = CBITS'(1);
        end else if (gap_q != C_GAP_MAX) begin
            gap_d = gap_q + CBITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

    assign gap_o = gap_q;

endmodule

`default_nettype wire

// File: rtl/pulse_monitor.sv
// ============================================================================
// Module   : pulse_monitor
// Purpose  : Checks a periodic one-cycle pulse train, tracks lock and errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_monitor
    import pulse_monitor_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int CBITS    = DEF_CBITS,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             lost,
    output logic             period_err,
    output logic [7:0]       err_cnt,
    output logic [CBITS-1:0] last_period
);

    localparam int               C_P        = N + 1;
    localparam int               C_NEED     = $clog2(C_P + TOL + 2);
    localparam int               C_RBITS    = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CBITS-1:0] C_GAP_LO   = CBITS'(C_P - TOL);
    localparam logic [CBITS-1:0] C_GAP_HI   = CBITS'(C_P + TOL);
    localparam logic [CBITS-1:0] C_GAP_LOST = CBITS'(C_P + TOL + 1);
    localparam logic [C_RBITS-1:0] C_LOCK   = C_RBITS'(LOCK_CNT);

    generate
        if (CBITS < C_NEED) begin : g_cbits_check
            $error("pulse_monitor: CBITS too small for N+1+TOL+2");
        end
    endgenerate

    // Async assert, synchronous release of the internal reset.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic [CBITS-1:0] gap;

    gap_counter #(
        .CBITS (CBITS)
    ) u_gap (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .clear_i   (!en),
        .restart_i (sig_in),
        .gap_o     (gap)
    );

    state_t             state_q, state_d;
    logic [C_RBITS-1:0] run_q, run_d;
    logic [7:0]         err_q, err_d;
    logic [CBITS-1:0]   last_q, last_d;
    logic               perr_q, perr_d;
    logic               locked_q, lost_q;
    logic               err_inc;
    logic               good;

    assign good = (gap >= C_GAP_LO) && (gap <= C_GAP_HI);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        last_d  = last_q;
        perr_d  = 1'b0;
        err_inc = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            run_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOST: begin
                    if (sig_in) begin
                        state_d = ST_ACQ;
                        run_d   = '0;
                    end
                end
                ST_ACQ, ST_LOCKED: begin
                    if (sig_in) begin
                        last_d = gap;
                        if (!good) begin
                            state_d = ST_ACQ;
                            run_d   = '0;
                            perr_d  = 1'b1;
                            err_inc = 1'b1;
                        end else if (state_q == ST_ACQ) begin
                            run_d = run_q + C_RBITS'(1);
                            if (run_q + C_RBITS'(1) == C_LOCK) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else if (gap >= C_GAP_LOST) begin
                        state_d = ST_LOST;
                        run_d   = '0;
                        err_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A clear request wins over any increment in the same cycle.
        err_d = err_q;
        if (clr_err) begin
            err_d = '0;
        end else if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= ST_IDLE;
            run_q    <= '0;
            err_q    <= '0;
            last_q   <= '0;
            perr_q   <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            err_q    <= err_d;
            last_q   <= last_d;
            perr_q   <= perr_d;
            locked_q <= (state_d == ST_LOCKED);
            lost_q   <= (state_d == ST_LOST);
        end
    end

    assign locked      = locked_q;
    assign lost        = lost_q;
    assign period_err  = perr_q;
    assign err_cnt     = err_q;
    assign last_period = last_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_monitor.sv
// ============================================================================
// Module   : tb_pulse_monitor
// Purpose  : Directed vector bench for pulse_monitor (scaled N=30, P=31).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_monitor;

    localparam int N        = 30;
    localparam int CBITS    = 6;
    localparam int TOL      = 2;
    localparam int LOCK_CNT = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             sig_in;
    logic             clr_err;
    logic             locked;
    logic             lost;
    logic             period_err;
    logic [7:0]       err_cnt;
    logic [CBITS-1:0] last_period;

    int checks;
    int errors;

    pulse_monitor #(
        .N        (N),
        .CBITS    (CBITS),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sig_in      (sig_in),
        .clr_err     (clr_err),
        .locked      (locked),
        .lost        (lost),
        .period_err  (period_err),
        .err_cnt     (err_cnt),
        .last_period (last_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         gap;
        bit         en_p;
        bit         clr_p;
        bit         e_locked;
        bit         e_lost;
        bit         e_perr;
        logic [7:0] e_err;
        logic [5:0] e_last;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input bit e_l, input bit e_lo, input bit e_pe,
                       input logic [7:0] e_err, input logic [5:0] e_last);
        logic [16:0] act;
        logic [16:0] exp;
        act = {locked, lost, period_err, err_cnt, last_period};
        exp = {e_l, e_lo, e_pe, e_err, e_last};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got locked=%b lost=%b perr=%b err=%0d last=%0d want locked=%b lost=%b perr=%b err=%0d last=%0d",
                     name, locked, lost, period_err, err_cnt, last_period,
                     e_l, e_lo, e_pe, e_err, e_last);
        end
    endtask

    // Pulse sampled g edges after the previous pulse; en/clr apply only on the pulse cycle.
    task automatic pulse(input int g, input bit en_p, input bit clr_p);
        sig_in  = 1'b0;
        en      = 1'b1;
        clr_err = 1'b0;
        repeat (g - 1) tick();
        sig_in  = 1'b1;
        en      = en_p;
        clr_err = clr_p;
        tick();
        sig_in  = 1'b0;
        en      = 1'b1;
        clr_err = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        sig_in  = 1'b0;
        clr_err = 1'b0;

        //            gap en clr  L LO PE err  last
        vecs[0]  = '{ 5,  1, 0,  0, 0, 0, 8'd0, 6'd0 };
        vecs[1]  = '{31,  1, 0,  0, 0, 0, 8'd0, 6'd31};
        vecs[2]  = '{31,  1, 0,  1, 0, 0, 8'd0, 6'd31};
        vecs[3]  = '{29,  1, 0,  1, 0, 0, 8'd0, 6'd29};
        vecs[4]  = '{33,  1, 0,  1, 0, 0, 8'd0, 6'd33};
        vecs[5]  = '{28,  1, 0,  0, 0, 1, 8'd1, 6'd28};
        vecs[6]  = '{31,  1, 0,  0, 0, 0, 8'd1, 6'd31};
        vecs[7]  = '{32,  1, 0,  1, 0, 0, 8'd1, 6'd32};
        vecs[8]  = '{34,  1, 0,  0, 0, 1, 8'd2, 6'd34};
        vecs[9]  = '{30,  1, 0,  0, 0, 0, 8'd2, 6'd30};
        vecs[10] = '{31,  0, 0,  0, 0, 0, 8'd2, 6'd30};
        vecs[11] = '{10,  1, 0,  0, 0, 0, 8'd2, 6'd30};
        vecs[12] = '{20,  1, 1,  0, 0, 1, 8'd0, 6'd20};
        vecs[13] = '{31,  1, 0,  0, 0, 0, 8'd0, 6'd31};
        vecs[14] = '{31,  1, 0,  1, 0, 0, 8'd0, 6'd31};

        #1;
        chk("reset_state", 0, 0, 0, 8'd0, 6'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("after_release", 0, 0, 0, 8'd0, 6'd0);

        for (int i = 0; i < 15; i++) begin
            pulse(vecs[i].gap, vecs[i].en_p, vecs[i].clr_p);
            chk($sformatf("vec%0d", i), vecs[i].e_locked, vecs[i].e_lost,
                vecs[i].e_perr, vecs[i].e_err, vecs[i].e_last);
        end

        // Missing pulse from LOCKED: LOST once the gap reaches P+TOL+1 = 34.
        sig_in = 1'b0;
        repeat (33) tick();
        chk("lost_not_yet", 1, 0, 0, 8'd0, 6'd31);
        tick();
        chk("lost_entered", 0, 1, 0, 8'd1, 6'd31);
        pulse(4, 1, 0);
        chk("lost_to_acq", 0, 0, 0, 8'd1, 6'd31);
        pulse(31, 1, 0);
        pulse(31, 1, 0);
        chk("relock", 1, 0, 0, 8'd1, 6'd31);

        // Asynchronous reset mid-cycle while locked with a nonzero error count.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 0, 0, 0, 8'd0, 6'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("reset_released", 0, 0, 0, 8'd0, 6'd0);

        // sig_in held high: every cycle after entering ACQ is a gap=1 bad period.
        sig_in = 1'b1;
        tick();
        chk("held_first", 0, 0, 0, 8'd0, 6'd0);
        tick();
        chk("held_second", 0, 0, 1, 8'd1, 6'd1);
        repeat (298) tick();
        chk("err_saturate", 0, 0, 1, 8'd255, 6'd1);
        sig_in  = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_after_sat", 0, 0, 0, 8'd0, 6'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
